// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_t;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead FIFO of scan-code entries; head is visible on dout
// whenever the FIFO is not empty. DEPTH must be a power of two.
module ps2_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_l,
   input  logic                           push,
   input  ps2_entry_t                     din,
   input  logic                           pop,
   output ps2_entry_t                     dout,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   ps2_entry_t       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // A pop frees a slot in the same cycle, so a push into a full FIFO still
   // lands when the consumer is draining.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keyrx.sv
// PS/2 keyboard receiver: pin synchronisers, clock glitch filter, frame FSM
// with parity/stop checks, idle watchdog and a buffered scan-code stream.
// Optional macro PS2_MAKEBREAK_EN folds E0/F0 prefixes into ext/brk flags.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (sample 0)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit, computing odd-parity result
// ST_STOP   | checking the stop bit, completing or discarding the byte
module ps2_keyrx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst_l,
   input  logic                              ps2_clk,
   input  logic                              ps2_data,
   output logic                              key_valid,
   input  logic                              key_ready,
   output logic [7:0]                        key_code,
   output logic                              key_ext,
   output logic                              key_brk,
   output logic                              parity_err,
   output logic                              frame_err,
   output logic                              overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

   localparam int FW = $clog2(FILTER_LEN+1);
   localparam int WW = $clog2(TIMEOUT_CYC+1);

   logic           clk_s1, clk_s2, dat_s1, dat_s2;
   logic [FW-1:0]  filt_cnt;
   logic           fclk, fclk_d, fall;
   ps2_state_t     state, state_nx;
   logic [2:0]     bit_cnt;
   logic [7:0]     shreg;
   logic           par_ok;
   logic [WW-1:0]  wd_cnt;
   logic           timeout, stop_hit, abort;
   logic           byte_ok, perr_c, ferr_c;
   logic           push, pop, full, empty;
   ps2_entry_t     entry, head;

   // Two-flop synchronisers; lines idle high.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // Clock filter: fclk follows only after FILTER_LEN equal differing samples.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         filt_cnt <= '0;
         fclk     <= 1'b1;
         fclk_d   <= 1'b1;
      end else begin
         fclk_d <= fclk;
         if (clk_s2 == fclk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN-1)) begin
            fclk     <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   assign fall    = fclk_d & ~fclk;
   // A fall in the same cycle counts as activity, so it wins over the watchdog.
   assign timeout = (state != ST_IDLE) && !fall && (wd_cnt == WW'(TIMEOUT_CYC-1));

   // Frame state register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; advances only on fall, except the watchdog abort.
   always_comb begin
      state_nx = state;
      stop_hit = 1'b0;
      abort    = 1'b0;
      if (timeout) begin
         state_nx = ST_IDLE;
         abort    = 1'b1;
      end else if (fall) begin
         case (state)
            ST_IDLE:   if (!dat_s2) state_nx = ST_DATA;
            ST_DATA:   if (bit_cnt == 3'd7) state_nx = ST_PARITY;
            ST_PARITY: state_nx = ST_STOP;
            ST_STOP: begin
               state_nx = ST_IDLE;
               stop_hit = 1'b1;
            end
            default:   state_nx = ST_IDLE;
         endcase
      end
   end

   // Shift register, bit counter, parity result and watchdog counter.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         bit_cnt <= '0;
         shreg   <= '0;
         par_ok  <= 1'b0;
         wd_cnt  <= '0;
      end else begin
         if (fall) begin
            case (state)
               ST_IDLE:   bit_cnt <= '0;
               ST_DATA: begin
                  shreg   <= {dat_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               ST_PARITY: par_ok <= ^{shreg, dat_s2};
               default:   ;
            endcase
         end
         if (fall || state == ST_IDLE) wd_cnt <= '0;
         else if (!timeout)            wd_cnt <= wd_cnt + WW'(1);
      end
   end

   assign byte_ok = stop_hit & par_ok & dat_s2;
   assign perr_c  = stop_hit & ~par_ok;
   assign ferr_c  = (stop_hit & ~dat_s2) | abort;
   assign pop     = key_valid & key_ready;

`ifdef PS2_MAKEBREAK_EN
   logic ext_pend, brk_pend, is_pfx;

   assign is_pfx = (shreg == PS2_PFX_EXT) || (shreg == PS2_PFX_BRK);
   assign push   = byte_ok & ~is_pfx;
   assign entry  = '{ext: ext_pend, brk: brk_pend, code: shreg};

   // Prefix flags wait for the next real scan code; framing trouble drops them.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (ferr_c) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (byte_ok) begin
         if (shreg == PS2_PFX_EXT)      ext_pend <= 1'b1;
         else if (shreg == PS2_PFX_BRK) brk_pend <= 1'b1;
         else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end
`else
   assign push  = byte_ok;
   assign entry = '{ext: 1'b0, brk: 1'b0, code: shreg};
`endif

   // One-cycle error and overflow pulses.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         parity_err <= perr_c;
         frame_err  <= ferr_c;
         overflow   <= push & full & ~pop;
      end
   end

   ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_l (rst_l),
      .push  (push),
      .din   (entry),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign key_valid = ~empty;
   assign key_code  = head.code;
   assign key_ext   = head.ext;
   assign key_brk   = head.brk;

endmodule

// File: tb/tb_ps2_keyrx.sv
// Directed bench for ps2_keyrx: frames are bit-banged on the PS/2 pins and
// the buffered stream, error pulses and occupancy are compared to hand values.
module tb_ps2_keyrx;

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_ready = 1'b0;
   logic       key_valid, key_ext, key_brk;
   logic [7:0] key_code;
   logic       parity_err, frame_err, overflow;
   logic [2:0] fifo_count;

   int n_chk = 0;
   int n_err = 0;
   int n_perr = 0;
   int n_ferr = 0;
   int n_ovf = 0;
   int p0, f0, o0;

   ps2_keyrx #(.FILTER_LEN(4), .TIMEOUT_CYC(200), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_brk    (key_brk),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   // Pulse counters; a pulse wider than one cycle counts more than once.
   always @(negedge clk) begin
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
      if (overflow)   n_ovf++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      idle(5);
      ps2_clk = 1'b0;
      idle(10);
      ps2_clk = 1'b1;
      idle(5);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((~^d) ^ bad_par);
      send_bit(~bad_stop);
      ps2_data = 1'b1;
      idle(10);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] code,
                             input logic ext, input logic brk);
      check({tag, ".valid"}, key_valid, 1'b1);
      check({tag, ".code"},  key_code,  code);
      check({tag, ".ext"},   key_ext,   ext);
      check({tag, ".brk"},   key_brk,   brk);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
   endtask

   initial begin
      idle(3);
      check("rst.valid", key_valid, 1'b0);
      check("rst.code",  key_code,  8'h00);
      check("rst.ext",   key_ext,   1'b0);
      check("rst.brk",   key_brk,   1'b0);
      check("rst.perr",  parity_err, 1'b0);
      check("rst.ferr",  frame_err,  1'b0);
      check("rst.ovf",   overflow,   1'b0);
      check("rst.count", fifo_count, 3'd0);
      rst_l = 1'b1;
      idle(5);

      // Good 0x1C frame.
      send_frame(8'h1C, 1'b0, 1'b0);
      check("good.count", fifo_count, 3'd1);
      pop_expect("good", 8'h1C, 1'b0, 1'b0);
      idle(1);
      check("good.empty", key_valid, 1'b0);
      check("good.count0", fifo_count, 3'd0);

      // Bad parity.
      p0 = n_perr; f0 = n_ferr;
      send_frame(8'h1C, 1'b1, 1'b0);
      check("par.pulse", n_perr - p0, 1);
      check("par.noferr", n_ferr - f0, 0);
      check("par.valid", key_valid, 1'b0);

      // Bad stop bit.
      p0 = n_perr; f0 = n_ferr;
      send_frame(8'h55, 1'b0, 1'b1);
      check("stop.ferr", n_ferr - f0, 1);
      check("stop.noperr", n_perr - p0, 0);
      check("stop.valid", key_valid, 1'b0);

      // Prefix sequence E0 F0 74.
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h74, 1'b0, 1'b0);
`ifdef PS2_MAKEBREAK_EN
      check("pfx.count", fifo_count, 3'd1);
      pop_expect("pfx74", 8'h74, 1'b1, 1'b1);
`else
      check("pfx.count", fifo_count, 3'd3);
      pop_expect("pfxE0", 8'hE0, 1'b0, 1'b0);
      pop_expect("pfxF0", 8'hF0, 1'b0, 1'b0);
      pop_expect("pfx74", 8'h74, 1'b0, 1'b0);
`endif
      idle(1);
      check("pfx.empty", key_valid, 1'b0);

      // Watchdog: start + 3 data bits, then silence.
      f0 = n_ferr;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      ps2_data = 1'b1;
      idle(300);
      check("wd.ferr", n_ferr - f0, 1);
      check("wd.valid", key_valid, 1'b0);
      send_frame(8'h2A, 1'b0, 1'b0);
      check("wd.count", fifo_count, 3'd1);
      pop_expect("wd2A", 8'h2A, 1'b0, 1'b0);

      // Overflow with depth 4.
      o0 = n_ovf;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
      check("ovf.pulse", n_ovf - o0, 1);
      check("ovf.count", fifo_count, 3'd4);
      pop_expect("ovf01", 8'h01, 1'b0, 1'b0);
      pop_expect("ovf02", 8'h02, 1'b0, 1'b0);
      pop_expect("ovf03", 8'h03, 1'b0, 1'b0);
      pop_expect("ovf04", 8'h04, 1'b0, 1'b0);
      idle(1);
      check("ovf.empty", key_valid, 1'b0);
      check("ovf.count0", fifo_count, 3'd0);

      // Short clock glitch with data low must not look like a start bit.
      p0 = n_perr; f0 = n_ferr;
      ps2_data = 1'b0;
      idle(8);
      ps2_clk = 1'b0;
      idle(3);
      ps2_clk = 1'b1;
      idle(12);
      ps2_data = 1'b1;
      idle(20);
      send_frame(8'h3B, 1'b0, 1'b0);
      check("glitch.count", fifo_count, 3'd1);
      pop_expect("glitch3B", 8'h3B, 1'b0, 1'b0);
      check("glitch.perr", n_perr - p0, 0);
      check("glitch.ferr", n_ferr - f0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ps2_keyrx.md
# ps2_keyrx

Parametrised PS/2 keyboard receiver with glitch filtering, odd-parity and framing checks, an idle watchdog, and a buffered scan-code output. It sits between the PS/2 connector pins and the Enigma keyboard decode logic. It replaces the single-byte, pulse-only key interface with a valid/ready stream, so bursts of scan codes are not lost while downstream logic is busy.

## Interface
- `FILTER_LEN`, 8: number of consecutive `clk` cycles a synchronised `ps2_clk` level must hold before the filtered clock changes; range ≥1.
- `TIMEOUT_CYC`, 50000: `clk` cycles without a filtered edge, mid-frame, before the frame is aborted; range ≥16.
- `FIFO_DEPTH`, 8: scan-code entries buffered; must be a power of two, ≥2.
- `clk` in 1: system clock; the only clock.
- `rst_l` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `key_valid` out 1: FIFO head holds an entry.
- `key_ready` in 1: consumer accepts the head this cycle.
- `key_code` out 8: head scan code.
- `key_ext` out 1: head was preceded by an 0xE0 prefix.
- `key_brk` out 1: head was preceded by an 0xF0 prefix (release).
- `parity_err` out 1: one-cycle pulse; parity check failed.
- `frame_err` out 1: one-cycle pulse; stop bit was 0, or the watchdog fired.
- `overflow` out 1: one-cycle pulse; a completed byte was dropped because the FIFO was full.
- `fifo_count` out `$clog2(FIFO_DEPTH+1)`: current occupancy.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through 2-flop synchronisers.
  - The synchronised clock feeds a saturating stability counter. The filtered clock `fclk` takes the new level only after `FILTER_LEN` equal consecutive samples.
  - `fall` is a one-cycle strobe on each 1→0 transition of `fclk`. The synchronised data bit is sampled on `fall`.
- Frame FSM. States IDLE, DATA, PARITY, STOP; transitions occur only on `fall`, except the watchdog abort.
  - IDLE: sample 0 → DATA, with the bit counter cleared. Sample 1 → stay in IDLE.
  - DATA: shift the sample in LSB-first and increment the 3-bit counter. After the 8th bit → PARITY.
  - PARITY: `par_ok = ^{data, sample}` (odd parity; the total number of ones must be odd). → STOP.
  - STOP: → IDLE in all cases.
    - If `par_ok` and sample=1: byte complete.
    - If `!par_ok`: `parity_err` pulses.
    - If sample=0: `frame_err` pulses. Both error pulses may fire together.
    - A byte with any error is discarded.
- Watchdog: the counter clears on every `fall` and while in IDLE. Reaching `TIMEOUT_CYC` in any other state → IDLE, `frame_err` pulses, and the partial byte is discarded.
- Prefix decode: see Configuration.
- FIFO:
  - Each entry is {ext, brk, code}, 10 bits, in show-ahead order. `key_*` outputs reflect the head.
  - Pop occurs when `key_valid & key_ready`.
  - Push when full without a simultaneous pop: the entry is dropped and `overflow` pulses.
  - Push when full with a simultaneous pop: both succeed.
  - Push and pop when empty: the push succeeds, and the pop is ignored because `key_valid` was 0.
- Reset mid-frame: the FSM returns to IDLE, the FIFO empties, pending prefixes clear, and filters reload to the idle-high level.

## Timing
- Reset values: `key_valid`=0, `key_code`=0, `key_ext`=0, `key_brk`=0, `parity_err`=0, `frame_err`=0, `overflow`=0, `fifo_count`=0. Filtered clock resets to 1.
- Edge latency: raw pin edge → `fall` takes 2 (synchroniser) + `FILTER_LEN` + 1 cycles.
- Data latency: with `fall` for the stop bit in cycle N:
  - FIFO write and error/overflow pulses occur in N+1.
  - `key_valid` is high in N+1 if the FIFO was empty.
- `fifo_count` updates in the cycle after push/pop.
- Output stability: `key_code`, `key_ext` and `key_brk` stay stable while `key_valid & !key_ready`.
- Every error pulse is exactly one cycle wide.

## Configuration
- `PS2_MAKEBREAK_EN` defined:
  - A completed 0xE0 sets an `ext_pend` flag, and a completed 0xF0 sets a `brk_pend` flag. Neither prefix is pushed.
  - The next non-prefix byte is pushed with `ext`/`brk` taken from the pending flags; both flags then clear.
  - A frame error or watchdog abort also clears both flags.
- `PS2_MAKEBREAK_EN` undefined:
  - Every completed byte, prefixes included, is pushed with `ext`=`brk`=0.
  - No pending-flag logic is present.

## Structure
- `ps2_pkg` holds:
  - the FSM state enum,
  - `PS2_PFX_EXT = 8'hE0` and `PS2_PFX_BRK = 8'hF0`,
  - the packed struct `ps2_entry_t` {ext, brk, code[7:0]}.
- Sub-module `ps2_fifo` is a synchronous show-ahead FIFO of `ps2_entry_t`, parametrised by `DEPTH`. It exposes push, pop, full, empty and count. The synchronisers, filter, FSM, watchdog and decoder stay in `ps2_keyrx`.

## Test plan
- Frame 0x1C with parity 0, stop 1 → `key_valid`=1, `key_code`=0x1C, `key_ext`=`key_brk`=0, `fifo_count`=1.
- Frame 0x1C with parity 1 → `parity_err` pulses once, `key_valid` stays 0.
- With `PS2_MAKEBREAK_EN`, frames E0, F0, 74 → one entry: `key_code`=0x74, `key_ext`=1, `key_brk`=1. Without the macro → three entries E0, F0, 74, all with flags 0.
- Start bit plus 3 data bits, then `ps2_clk` held high for `TIMEOUT_CYC` cycles → `frame_err` pulses and the FSM is in IDLE. A following 0x2A frame is received correctly.
- `FIFO_DEPTH`=4, `key_ready`=0, five frames 0x01–0x05 → `overflow` pulses once and `fifo_count`=4. Draining yields 01, 02, 03, 04.
- A `ps2_clk` low glitch lasting `FILTER_LEN`-1 cycles while in IDLE → no `fall` and no state change. A subsequent valid frame is received intact.
